// File: rtl/ysyx_22040759_id_stage.sv
// ysyx_22040759_id_stage: RV64 decode stage -- regfile read, EX/MEM/WB forwarding, immediate
// generation and load-use stall. Define YSYX_22040759_ID_PERF_EN to add stall/flush counters.
module ysyx_22040759_id_stage #(
  parameter int PC_W   = 64,
  parameter int INST_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fs_to_ds_valid,
  input  logic [INST_W+PC_W-1:0]   fs_to_ds_bus,
  output logic                     ds_allowin,
  input  logic                     es_allowin,
  output logic                     ds_to_es_valid,
  output logic [INST_W+4*PC_W+5:0] ds_to_es_bus,
  output logic [4:0]               rf_raddr1,
  output logic [4:0]               rf_raddr2,
  input  logic [PC_W-1:0]          rf_rdata1,
  input  logic [PC_W-1:0]          rf_rdata2,
  input  logic [PC_W+6:0]          es_fwd_bus,
  input  logic [PC_W+6:0]          ms_fwd_bus,
  input  logic [PC_W+6:0]          ws_fwd_bus,
  input  logic                     es_load,
  input  logic                     blu_brush_flag
`ifdef YSYX_22040759_ID_PERF_EN
  ,
  output logic [63:0]              ds_stall_cnt,
  output logic [63:0]              ds_flush_cnt
`endif
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;

  logic              ds_valid;
  logic [INST_W-1:0] ds_inst;
  logic [PC_W-1:0]   ds_pc;
  logic              ds_ready_go;

  logic [6:0]        opcode;
  logic [4:0]        rs1, rs2, rd;
  logic [PC_W-1:0]   imm, src1, src2;
  logic              use_rs1, use_rs2, rd_wen, load_use;
  logic [4:0]        es_rd;

  assign opcode    = ds_inst[6:0];
  assign rs1       = ds_inst[19:15];
  assign rs2       = ds_inst[24:20];
  assign rd        = ds_inst[11:7];
  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;

  always_comb begin
    imm = '0;
    unique case (opcode)
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM:
        imm = {{(PC_W-12){ds_inst[31]}}, ds_inst[31:20]};
      OP_STORE:
        imm = {{(PC_W-12){ds_inst[31]}}, ds_inst[31:25], ds_inst[11:7]};
      OP_BRANCH:
        imm = {{(PC_W-13){ds_inst[31]}}, ds_inst[31], ds_inst[7], ds_inst[30:25],
               ds_inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {{(PC_W-32){ds_inst[31]}}, ds_inst[31:12], 12'h000};
      OP_JAL:
        imm = {{(PC_W-21){ds_inst[31]}}, ds_inst[31], ds_inst[19:12], ds_inst[20],
               ds_inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  assign use_rs1 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
  assign use_rs2 = (opcode == OP_OP) || (opcode == OP_OP32) ||
                   (opcode == OP_STORE) || (opcode == OP_BRANCH);
  assign rd_wen  = !(opcode == OP_STORE || opcode == OP_BRANCH) && (rd != 5'd0);

  function automatic logic fwd_hit(input logic [PC_W+6:0] fb, input logic [4:0] rs);
    return fb[PC_W+6] && fb[PC_W+5] && (fb[PC_W+4:PC_W] == rs);
  endfunction

  // Youngest producer wins: EX, then MEM, then WB, then the architectural file.
  function automatic logic [PC_W-1:0] fwd_src(input logic [4:0] rs,
                                              input logic [PC_W-1:0] rf,
                                              input logic [PC_W+6:0] es,
                                              input logic [PC_W+6:0] ms,
                                              input logic [PC_W+6:0] ws);
    logic [PC_W-1:0] r;
    if (rs == 5'd0)          r = '0;
    else if (fwd_hit(es, rs)) r = es[PC_W-1:0];
    else if (fwd_hit(ms, rs)) r = ms[PC_W-1:0];
    else if (fwd_hit(ws, rs)) r = ws[PC_W-1:0];
    else                      r = rf;
    return r;
  endfunction

  assign src1 = fwd_src(rs1, rf_rdata1, es_fwd_bus, ms_fwd_bus, ws_fwd_bus);
  assign src2 = fwd_src(rs2, rf_rdata2, es_fwd_bus, ms_fwd_bus, ws_fwd_bus);

  // A load in EX has no data yet, so its consumer must wait one cycle.
  assign es_rd    = es_fwd_bus[PC_W+4:PC_W];
  assign load_use = es_load && es_fwd_bus[PC_W+6] && (es_rd != 5'd0) &&
                    ((use_rs1 && es_rd == rs1) || (use_rs2 && es_rd == rs2));

  assign ds_ready_go    = !load_use;
  assign ds_allowin     = !ds_valid || (ds_ready_go && es_allowin);
  assign ds_to_es_valid = ds_valid && ds_ready_go && !blu_brush_flag;
  assign ds_to_es_bus   = {ds_inst, ds_pc, imm, src1, src2, rd_wen, rd};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ds_valid <= 1'b0;
      ds_inst  <= '0;
      ds_pc    <= '0;
    end else if (blu_brush_flag) begin
      ds_valid <= 1'b0;
    end else if (ds_allowin) begin
      ds_valid <= fs_to_ds_valid;
      if (fs_to_ds_valid) begin
        ds_inst <= fs_to_ds_bus[INST_W+PC_W-1:PC_W];
        ds_pc   <= fs_to_ds_bus[PC_W-1:0];
      end
    end
  end

`ifdef YSYX_22040759_ID_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ds_stall_cnt <= '0;
      ds_flush_cnt <= '0;
    end else begin
      if (ds_valid && !ds_ready_go && !blu_brush_flag) ds_stall_cnt <= ds_stall_cnt + 64'd1;
      if (blu_brush_flag && ds_valid)                  ds_flush_cnt <= ds_flush_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22040759_id_stage.sv
// Scoreboard bench for ysyx_22040759_id_stage: directed scenarios then randomized traffic,
// expected responses queued per cycle and checked by an independent monitor.
module tb_ysyx_22040759_id_stage;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fs_to_ds_valid = 1'b0;
  logic [95:0]  fs_to_ds_bus = '0;
  logic         ds_allowin;
  logic         es_allowin = 1'b1;
  logic         ds_to_es_valid;
  logic [293:0] ds_to_es_bus;
  logic [4:0]   rf_raddr1, rf_raddr2;
  logic [63:0]  rf_rdata1, rf_rdata2;
  logic [70:0]  es_fwd_bus = '0, ms_fwd_bus = '0, ws_fwd_bus = '0;
  logic         es_load = 1'b0;
  logic         blu_brush_flag = 1'b0;
`ifdef YSYX_22040759_ID_PERF_EN
  logic [63:0]  ds_stall_cnt, ds_flush_cnt;
  logic [63:0]  m_stall, m_flush;
`endif

  always #5 clk = ~clk;

  logic [63:0] regs [32];
  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];

  ysyx_22040759_id_stage dut (
    .clk(clk), .rst(rst),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .ds_allowin(ds_allowin), .es_allowin(es_allowin),
    .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(ds_to_es_bus),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .es_fwd_bus(es_fwd_bus), .ms_fwd_bus(ms_fwd_bus), .ws_fwd_bus(ws_fwd_bus),
    .es_load(es_load), .blu_brush_flag(blu_brush_flag)
`ifdef YSYX_22040759_ID_PERF_EN
    , .ds_stall_cnt(ds_stall_cnt), .ds_flush_cnt(ds_flush_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [293:0] act, input logic [293:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic         v;
    logic         a;
    logic [293:0] bus;
    logic [4:0]   r1;
    logic [4:0]   r2;
    logic [63:0]  sc;
    logic [63:0]  fc;
  } exp_t;
  exp_t q[$];

  // reference model: one-entry slot holding the decoded instruction
  logic        mv;
  logic [31:0] mi;
  logic [63:0] mp;
  logic        cur_stall, cur_allow;

  logic        t_rst, t_fv, t_ea, t_el, t_fl;
  logic [31:0] t_inst;
  logic [63:0] t_pc;
  logic [70:0] t_ef, t_mf, t_wf;

  function automatic logic [63:0] imm_of(input logic [31:0] i);
    logic signed [63:0] v;
    case (i[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67, 7'h73: v = $signed(i[31:20]);
      7'h23: v = $signed({i[31:25], i[11:7]});
      7'h63: v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
      7'h37, 7'h17: v = $signed({i[31:12], 12'h000});
      7'h6F: v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
      default: v = 64'sd0;
    endcase
    return v;
  endfunction

  function automatic logic reads_rs1(input logic [6:0] op);
    return !(op inside {7'h37, 7'h17, 7'h6F});
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    return op inside {7'h33, 7'h3B, 7'h23, 7'h63};
  endfunction

  function automatic logic [63:0] src_of(input logic [4:0] r, input logic [70:0] e,
                                         input logic [70:0] m, input logic [70:0] w);
    logic [70:0] st [3];
    st[0] = e; st[1] = m; st[2] = w;
    if (r == 5'd0) return 64'd0;
    for (int k = 0; k < 3; k++)
      if (st[k][70] && st[k][69] && st[k][68:64] == r) return st[k][63:0];
    return regs[r];
  endfunction

  task automatic idle();
    t_rst = 0; t_fv = 0; t_inst = 32'h0; t_pc = 64'h0; t_ea = 1; t_el = 0;
    t_ef = '0; t_mf = '0; t_wf = '0; t_fl = 0;
  endtask

  task automatic drive();
    exp_t e;
    logic [4:0] r1, r2, erd;
    logic       wen;
    @(negedge clk);
    rst = t_rst; fs_to_ds_valid = t_fv; fs_to_ds_bus = {t_inst, t_pc};
    es_allowin = t_ea; es_load = t_el; es_fwd_bus = t_ef; ms_fwd_bus = t_mf;
    ws_fwd_bus = t_wf; blu_brush_flag = t_fl;
    if (t_rst) begin
      mv = 0; mi = '0; mp = '0;
`ifdef YSYX_22040759_ID_PERF_EN
      m_stall = '0; m_flush = '0;
`endif
    end
    #1;
    r1  = mi[19:15];
    r2  = mi[24:20];
    erd = t_ef[68:64];
    wen = !(mi[6:0] inside {7'h23, 7'h63}) && (mi[11:7] != 5'd0);
    cur_stall = t_el && t_ef[70] && erd != 5'd0 &&
                ((reads_rs1(mi[6:0]) && erd == r1) || (reads_rs2(mi[6:0]) && erd == r2));
    cur_allow = !mv || (!cur_stall && t_ea);
    e.v   = mv && !cur_stall && !t_fl;
    e.a   = cur_allow;
    e.bus = {mi, mp, imm_of(mi), src_of(r1, t_ef, t_mf, t_wf), src_of(r2, t_ef, t_mf, t_wf),
             wen, mi[11:7]};
    e.r1  = r1;
    e.r2  = r2;
`ifdef YSYX_22040759_ID_PERF_EN
    e.sc = m_stall; e.fc = m_flush;
`else
    e.sc = '0; e.fc = '0;
`endif
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    if (!t_rst) begin
`ifdef YSYX_22040759_ID_PERF_EN
      if (mv && cur_stall && !t_fl) m_stall = m_stall + 1;
      if (t_fl && mv)               m_flush = m_flush + 1;
`endif
      if (t_fl) mv = 0;
      else if (cur_allow) begin
        mv = t_fv;
        if (t_fv) begin mi = t_inst; mp = t_pc; end
      end
    end
  endtask

  task automatic cyc();
    drive();
    step();
  endtask

  // monitor: one expected record per cycle, compared away from the clock edge
  exp_t me;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_empty: got no expected record for this cycle (t=%0t)", $time);
      end else begin
        me = q.pop_front();
        chk("sb_valid",   {293'd0, ds_to_es_valid}, {293'd0, me.v});
        chk("sb_allowin", {293'd0, ds_allowin},     {293'd0, me.a});
        chk("sb_raddr1",  {289'd0, rf_raddr1},      {289'd0, me.r1});
        chk("sb_raddr2",  {289'd0, rf_raddr2},      {289'd0, me.r2});
        if (me.v) chk("sb_bus", ds_to_es_bus, me.bus);
`ifdef YSYX_22040759_ID_PERF_EN
        chk("sb_stall_cnt", {230'd0, ds_stall_cnt}, {230'd0, me.sc});
        chk("sb_flush_cnt", {230'd0, ds_flush_cnt}, {230'd0, me.fc});
`endif
      end
    end
  end

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [14];
    logic [31:0] i;
    ops = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F,
            7'h33, 7'h3B, 7'h0F, 7'h7F};
    i = $urandom;
    i[6:0]   = ops[$urandom_range(0, 13)];
    i[11:7]  = 5'($urandom_range(0, 4));
    i[19:15] = 5'($urandom_range(0, 4));
    i[24:20] = 5'($urandom_range(0, 4));
    return i;
  endfunction

  function automatic logic [70:0] rand_fwd();
    return {1'($urandom), 1'($urandom), 5'($urandom_range(0, 4)), $urandom, $urandom};
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
    regs[0] = 64'hDEAD_BEEF_0000_0001;
    regs[1] = 64'h0;
    mv = 0; mi = '0; mp = '0; cur_stall = 0; cur_allow = 1;
`ifdef YSYX_22040759_ID_PERF_EN
    m_stall = '0; m_flush = '0;
`endif

    idle(); t_rst = 1; cyc(); cyc();
    idle(); drive(); #1;
    chk("rst_valid",   {293'd0, ds_to_es_valid}, 294'd0);
    chk("rst_allowin", {293'd0, ds_allowin},     294'd1);
    step();

    // reset mid-run discards the held instruction at once
    idle(); t_fv = 1; t_inst = 32'h0010_8133; t_pc = 64'h8000_0100; cyc();
    idle(); t_rst = 1; drive(); #1;
    chk("midrst_valid",   {293'd0, ds_to_es_valid}, 294'd0);
    chk("midrst_allowin", {293'd0, ds_allowin},     294'd1);
    step();
    idle(); cyc();

    // addi x1,x0,10
    idle(); t_fv = 1; t_inst = 32'h00A0_0093; t_pc = 64'h8000_0000; cyc();
    idle(); drive(); #1;
    chk("addi_valid", {293'd0, ds_to_es_valid},    294'd1);
    chk("addi_imm",   {230'd0, ds_to_es_bus[197:134]}, 294'd10);
    chk("addi_src1",  {230'd0, ds_to_es_bus[133:70]},  294'd0);
    chk("addi_rd",    {289'd0, ds_to_es_bus[4:0]},     294'd1);
    chk("addi_wen",   {293'd0, ds_to_es_bus[5]},       294'd1);
    step();

    // back-to-back with EX forward beating MEM/WB/regfile
    idle(); t_fv = 1; t_inst = 32'h0050_0093; t_pc = 64'h8000_0004; cyc();
    idle(); t_fv = 1; t_inst = 32'h0010_8133; t_pc = 64'h8000_0008; cyc();
    idle(); t_ef = {2'b11, 5'd1, 64'h5}; t_mf = {2'b11, 5'd1, 64'h77};
    t_wf = {2'b11, 5'd1, 64'h99}; drive(); #1;
    chk("fwd_src1", {230'd0, ds_to_es_bus[133:70]}, 294'h5);
    chk("fwd_src2", {230'd0, ds_to_es_bus[69:6]},   294'h5);
    step();

    // load-use stall on x3
    idle(); t_fv = 1; t_inst = 32'h0001_8233; t_pc = 64'h8000_0010; cyc();
    idle(); t_el = 1; t_ef = {2'b11, 5'd3, 64'h1234}; t_fv = 1; t_inst = 32'h13;
    drive(); #1;
    chk("lu_valid",   {293'd0, ds_to_es_valid}, 294'd0);
    chk("lu_allowin", {293'd0, ds_allowin},     294'd0);
    step();
    idle(); drive(); #1;
    chk("lu_issue",   {293'd0, ds_to_es_valid}, 294'd1);
    chk("lu_inst",    {262'd0, ds_to_es_bus[293:262]}, {262'd0, 32'h0001_8233});
    step();
    idle(); drive(); #1;
    chk("lu_once",    {293'd0, ds_to_es_valid}, 294'd0);
    step();

    // backpressure for three cycles while fetch keeps offering a word
    idle(); t_fv = 1; t_inst = 32'h00A0_0093; t_pc = 64'h8000_0020; cyc();
    for (int k = 0; k < 3; k++) begin
      idle(); t_ea = 0; t_fv = 1; t_inst = 32'h0000_0013; t_pc = 64'h8000_0024; drive(); #1;
      chk("bp_allowin", {293'd0, ds_allowin}, 294'd0);
      chk("bp_inst",    {262'd0, ds_to_es_bus[293:262]}, {262'd0, 32'h00A0_0093});
      step();
    end
    idle(); drive(); #1;
    chk("bp_issue", {293'd0, ds_to_es_valid}, 294'd1);
    step();
    idle(); drive(); #1;
    chk("bp_nolatch", {293'd0, ds_to_es_valid}, 294'd0);
    step();

    // flush of a held beq with fetch offering a nop
    idle(); t_fv = 1; t_inst = 32'h0000_0463; t_pc = 64'h8000_0030; cyc();
    idle(); t_fl = 1; t_fv = 1; t_inst = 32'h0000_0013; drive(); #1;
    chk("flush_valid", {293'd0, ds_to_es_valid}, 294'd0);
    step();
    idle(); drive(); #1;
    chk("flush_after", {293'd0, ds_to_es_valid}, 294'd0);
    chk("flush_allow", {293'd0, ds_allowin},     294'd1);
    step();

    // immediates: jal, sd, lui issued back to back
    idle(); t_fv = 1; t_inst = 32'h0080_006F; cyc();
    idle(); t_fv = 1; t_inst = 32'hFE11_3C23; drive(); #1;
    chk("jal_imm", {230'd0, ds_to_es_bus[197:134]}, 294'd8);
    step();
    idle(); t_fv = 1; t_inst = 32'h1234_50B7; drive(); #1;
    chk("sd_imm", {230'd0, ds_to_es_bus[197:134]}, {230'd0, 64'hFFFF_FFFF_FFFF_FFF8});
    chk("sd_wen", {293'd0, ds_to_es_bus[5]}, 294'd0);
    step();
    idle(); drive(); #1;
    chk("lui_imm", {230'd0, ds_to_es_bus[197:134]}, {230'd0, 64'h0000_0000_1234_5000});
    step();

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      t_rst  = ($urandom_range(0, 99) == 0);
      t_fv   = ($urandom_range(0, 3) != 0);
      t_inst = rand_inst();
      t_pc   = {$urandom, $urandom};
      t_ea   = ($urandom_range(0, 3) != 0);
      t_el   = ($urandom_range(0, 2) == 0);
      t_ef   = rand_fwd();
      t_mf   = rand_fwd();
      t_wf   = rand_fwd();
      t_fl   = ($urandom_range(0, 9) == 0);
      cyc();
    end

    #4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
